io_input_debouncer: RTL
=======================

Name: io_input_debouncer

Overview:
- Parametrised input conditioner for board switches and push-buttons ahead of the RV32I processor's memory-mapped IO (io_sw_i / io_push_i paths).
- Per channel: metastability synchroniser, consecutive-sample debounce counter, registered stable level, one-cycle rise/fall pulses and a sticky event bit the CPU clears by mask.
- Next generation of the plain switch pass-through, with configurable channel count, filter length and synchroniser depth.

Parameters:
- NUM_CH, 32, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive differing synchronised samples required to accept a new level (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset. Asynchronous, active-low, one clock domain.
- raw_i  input  NUM_CH  asynchronous raw switch/button levels.
- evt_clr_i  input  NUM_CH  per-channel sticky-event clear, sampled each clock.
- stable_o  output  NUM_CH  debounced level.
- rise_o  output  NUM_CH  one-cycle pulse on stable 0->1.
- fall_o  output  NUM_CH  one-cycle pulse on stable 1->0.
- evt_o  output  NUM_CH  sticky "edge occurred" flags.

Behaviour:
- Reset (rst_ni=0, asynchronous): all synchroniser flops, counters, stable_o, rise_o, fall_o and evt_o are cleared to 0 immediately, independent of the clock.
- Synchroniser: raw_i shifts through SYNC_STAGES flops. sync_q is the last stage.
- Counter per channel, width $clog2(DEBOUNCE_CYCLES+1):
  - sync_q == stable_o: counter <= 0.
  - sync_q != stable_o and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync_q != stable_o and counter == DEBOUNCE_CYCLES-1: stable_o <= sync_q and counter <= 0.
- Latency: a raw change held steady changes stable_o on exactly the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after raw_i settles before an edge.
- Glitch rule: a synchronised deviation lasting fewer than DEBOUNCE_CYCLES cycles never changes stable_o. Any return to the stable level restarts the count from 0.
- Edge pulses: rise_o / fall_o are registered and assert on the same edge where stable_o flips. They last exactly one cycle and are never both set on one channel.
- Sticky events: evt_o[i] <= (evt_o[i] & ~evt_clr_i[i]) | rise_o_next[i] | fall_o_next[i].
  - Simultaneous set and clear: set wins.
  - Clearing an already-clear bit has no effect.
- Channels are fully independent. No cross-channel arbitration.
- DEBOUNCE_CYCLES=1: stable_o follows sync_q with one extra register cycle.
- Reset mid-count: the count is discarded. After release, a full SYNC_STAGES+DEBOUNCE_CYCLES window is needed again.

Optional Feature:
- Macro IO_DEBOUNCE_IRQ_EN.
- When defined, adds:
  - irq_mask_i  input  NUM_CH.
  - irq_o  output  1, registered, = |(evt_o & irq_mask_i), reset 0, one cycle after evt_o/mask change.
- When undefined: both ports are absent and no IRQ logic exists. All other behaviour is identical.

Decomposition:
- Shared package io_pkg holds:
  - localparam defaults IO_NUM_CH_DEFAULT=32, IO_DEBOUNCE_DEFAULT=16, IO_SYNC_DEFAULT=2.
  - typedef io_edge_e {EDGE_NONE, EDGE_RISE, EDGE_FALL} for bench and monitor use.
- One natural sub-module: io_debounce_ch, a single-channel synchroniser + counter + stable/rise/fall.
- The top generates NUM_CH instances and holds the sticky event and IRQ logic.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: drive raw_i=4'hF during rst_ni=0 -> all outputs 0. After release, stable_o=4'hF at edge 6, rise_o=4'hF for that one cycle, evt_o=4'hF.
- Clean edge: raw_i[0] 0->1 held -> stable_o[0]=1 at edge 6. rise_o[0] pulses 1 cycle. Then raw_i[0] 1->0 -> fall_o[0] pulses at edge 6. evt_o[0] stays 1.
- Glitch reject: raw_i[1] high 3 cycles then low, repeated 5 times -> stable_o[1], rise_o[1], fall_o[1], evt_o[1] remain 0.
- Clear vs set: evt_o[2]=1, pulse evt_clr_i=4'h4 -> evt_o[2]=0 next cycle. Assert evt_clr_i[2] on the same edge as a new rise_o[2] -> evt_o[2] stays 1.
- Reset mid-count: raw_i[3]=1 for 4 cycles, then rst_ni=0 for 1 cycle -> all cleared. After release stable_o[3] rises only at edge 6, not earlier.
- IO_DEBOUNCE_IRQ_EN: irq_mask_i=4'h1, event on channel 2 -> irq_o=0. Event on channel 0 -> irq_o=1 one cycle after evt_o[0]. evt_clr_i=4'h1 -> irq_o=0 next cycle.

Source files
------------

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared defaults and edge-type encoding for the input debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int IO_NUM_CH_DEFAULT   = 32;
    localparam int IO_DEBOUNCE_DEFAULT = 16;
    localparam int IO_SYNC_DEFAULT     = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } io_edge_e;

endpackage
`default_nettype wire

// File: rtl/io_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : io_debounce_ch
// Purpose  : Single-channel synchroniser, debounce counter, stable level and
//            registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module io_debounce_ch
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = IO_SYNC_DEFAULT
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     i_raw,
    output logic     o_stable,
    output logic     o_rise,
    output logic     o_fall,
    output io_edge_e o_edge_nxt
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_sync_q;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_stable_nxt;
    io_edge_e               w_edge_nxt;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Any sample matching the stable level restarts the count from zero.
    always_comb begin
        w_cnt_nxt    = '0;
        w_stable_nxt = r_stable;
        w_edge_nxt   = EDGE_NONE;
        if (w_sync_q != r_stable) begin
            if (r_cnt == c_cnt_last) begin
                w_stable_nxt = w_sync_q;
                w_edge_nxt   = w_sync_q ? EDGE_RISE : EDGE_FALL;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= (w_edge_nxt == EDGE_RISE);
            r_fall   <= (w_edge_nxt == EDGE_FALL);
        end
    end

    assign o_stable   = r_stable;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_edge_nxt = w_edge_nxt;

endmodule
`default_nettype wire

// File: rtl/io_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : io_input_debouncer
// Purpose  : NUM_CH debounced inputs with edge pulses and sticky event flags.
//            Define IO_DEBOUNCE_IRQ_EN to add irq_mask_i / irq_o.
// Revision : 1.0 - initial release
// ============================================================================
module io_input_debouncer
    import io_pkg::*;
#(
    parameter int NUM_CH          = IO_NUM_CH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = IO_SYNC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] raw_i,
    input  logic [NUM_CH-1:0] evt_clr_i,
    output logic [NUM_CH-1:0] stable_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] evt_o
`ifdef IO_DEBOUNCE_IRQ_EN
    ,
    input  logic [NUM_CH-1:0] irq_mask_i,
    output logic              irq_o
`endif
);

    logic [NUM_CH-1:0] w_evt_set;
    logic [NUM_CH-1:0] r_evt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        io_edge_e w_edge_nxt;

        io_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .i_raw      (raw_i[gi]),
            .o_stable   (stable_o[gi]),
            .o_rise     (rise_o[gi]),
            .o_fall     (fall_o[gi]),
            .o_edge_nxt (w_edge_nxt)
        );

        assign w_evt_set[gi] = (w_edge_nxt != EDGE_NONE);
    end

    // A new edge on the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~evt_clr_i) | w_evt_set;
        end
    end

    assign evt_o = r_evt;

`ifdef IO_DEBOUNCE_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_evt & irq_mask_i);
        end
    end

    assign irq_o = r_irq;
`endif

endmodule
`default_nettype wire
